iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/alu_pkg.sv | 31 +++
 rtl/iter_alu_if.sv | 24 ++
 rtl/iter_alu_mul.sv | 54 +++++
 rtl/iter_alu.sv | 180 ++++++++++++++++++
 tb/tb_iter_alu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: opcode encoding, flag bit positions
// and controller state encoding.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_SHL   = 5'd5,
      OP_SHR   = 5'd6,
      OP_SRA   = 5'd7,
      OP_MUL   = 5'd8,
      OP_MULHU = 5'd9
   } alu_op_e;

   localparam int FLAGS_W      = 5;
   localparam int FLAG_ZERO    = 0;
   localparam int FLAG_NEG     = 1;
   localparam int FLAG_CARRY   = 2;
   localparam int FLAG_OVF     = 3;
   localparam int FLAG_ILLEGAL = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

endpackage

// File: rtl/iter_alu_if.sv
// Request/response handshake bundle for iter_alu.
interface iter_alu_if #(parameter int OPERAND_WIDTH = 32);
   import alu_pkg::*;

   logic                     in_valid;
   logic                     in_ready;
   logic [4:0]               operation;
   logic [OPERAND_WIDTH-1:0] lhs;
   logic [OPERAND_WIDTH-1:0] rhs;
   logic                     out_valid;
   logic                     out_ready;
   logic [OPERAND_WIDTH-1:0] result;
   logic [FLAGS_W-1:0]       flags;

   modport master (
      output in_valid, operation, lhs, rhs, out_ready,
      input  in_ready, out_valid, result, flags
   );

   modport slave (
      input  in_valid, operation, lhs, rhs, out_ready,
      output in_ready, out_valid, result, flags
   );
endinterface

// File: rtl/iter_alu_mul.sv
// Shift-add multiplier: one partial product per cycle, OPERAND_WIDTH steps.
// done is high during the final step; product then carries the value the
// accumulator takes at that edge, so the caller can capture it in step.
module iter_alu_mul #(
   parameter int OPERAND_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [OPERAND_WIDTH-1:0]   lhs,
   input  logic [OPERAND_WIDTH-1:0]   rhs,
   output logic                       done,
   output logic [2*OPERAND_WIDTH-1:0] product
);
   localparam int               W         = OPERAND_WIDTH;
   localparam int               CW        = $clog2(OPERAND_WIDTH);
   localparam logic [CW-1:0]    LAST_STEP = CW'(OPERAND_WIDTH - 1);

   logic              busy_r;
   logic [2*W-1:0]    acc_r;
   logic [2*W-1:0]    mcand_r;
   logic [W-1:0]      mplier_r;
   logic [CW-1:0]     step_r;
   logic [2*W-1:0]    acc_next_s;

   assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*W){1'b0}});
   assign done       = busy_r && (step_r == LAST_STEP);
   assign product    = acc_next_s;

   // Load operands on start, then add/shift once per cycle until the last step.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r   <= 1'b0;
         acc_r    <= {(2*W){1'b0}};
         mcand_r  <= {(2*W){1'b0}};
         mplier_r <= {W{1'b0}};
         step_r   <= {CW{1'b0}};
      end else if (start) begin
         busy_r   <= 1'b1;
         acc_r    <= {(2*W){1'b0}};
         mcand_r  <= {{W{1'b0}}, lhs};
         mplier_r <= rhs;
         step_r   <= {CW{1'b0}};
      end else if (busy_r) begin
         acc_r    <= acc_next_s;
         mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
         mplier_r <= {1'b0, mplier_r[W-1:1]};
         step_r   <= done ? {CW{1'b0}} : step_r + CW'(1);
         busy_r   <= !done;
      end else begin
         busy_r   <= busy_r;
      end
   end
endmodule

// File: rtl/iter_alu.sv
// Iterative ALU with valid/ready request and response handshakes.
// One operation in flight; single-cycle ops complete with latency 1.
// Optional feature macro: ITER_ALU_MUL_EN enables MUL/MULHU through the
// multi-cycle shift-add multiplier; without it opcodes 8/9 are illegal.
module iter_alu
   import alu_pkg::*;
#(
   parameter int OPERAND_WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   iter_alu_if.slave  bus
);
   localparam int W   = OPERAND_WIDTH;
   localparam int SHW = $clog2(OPERAND_WIDTH);

   alu_state_e         state_r, next_state_s;
   logic [W-1:0]       result_r;
   logic [FLAGS_W-1:0] flags_r;

   alu_op_e            op_s;
   logic               in_ready_s, accept_s;
   logic               is_mul_s, mul_done_s, load_alu_s, load_mul_s;
   logic [W-1:0]       mul_result_s;
   logic [W:0]         sum_s, diff_s;
   logic [SHW-1:0]     shamt_s;
   logic [W-1:0]       alu_result_s;
   logic               alu_carry_s, alu_ovf_s, alu_illegal_s;
   logic [FLAGS_W-1:0] alu_flags_s, mul_flags_s;

   assign op_s       = alu_op_e'(bus.operation);
   assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;
   assign load_alu_s = accept_s && !is_mul_s;
   assign load_mul_s = (state_r == ST_BUSY) && mul_done_s;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = (state_r == ST_DONE);
   assign bus.result    = result_r;
   assign bus.flags     = flags_r;

`ifdef ITER_ALU_MUL_EN
   logic           mul_start_s;
   logic           mul_hi_r;
   logic [2*W-1:0] mul_product_s;

   assign is_mul_s     = (op_s == OP_MUL) || (op_s == OP_MULHU);
   assign mul_start_s  = accept_s && is_mul_s;
   assign mul_result_s = mul_hi_r ? mul_product_s[2*W-1:W] : mul_product_s[W-1:0];

   iter_alu_mul #(.OPERAND_WIDTH(W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .lhs     (bus.lhs),
      .rhs     (bus.rhs),
      .done    (mul_done_s),
      .product (mul_product_s)
   );

   // Remember which half of the product the accepted request wants.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_hi_r <= 1'b0;
      end else if (mul_start_s) begin
         mul_hi_r <= (op_s == OP_MULHU);
      end else begin
         mul_hi_r <= mul_hi_r;
      end
   end
`else
   assign is_mul_s     = 1'b0;
   assign mul_done_s   = 1'b0;
   assign mul_result_s = {W{1'b0}};
`endif

   assign sum_s   = {1'b0, bus.lhs} + {1'b0, bus.rhs};
   assign diff_s  = {1'b0, bus.lhs} + {1'b0, ~bus.rhs} + {{W{1'b0}}, 1'b1};
   assign shamt_s = bus.rhs[SHW-1:0];

   // Single-cycle datapath evaluated on the offered operands.
   always_comb begin
      alu_result_s  = {W{1'b0}};
      alu_carry_s   = 1'b0;
      alu_ovf_s     = 1'b0;
      alu_illegal_s = 1'b0;
      case (op_s)
         OP_ADD: begin
            alu_result_s = sum_s[W-1:0];
            alu_carry_s  = sum_s[W];
            alu_ovf_s    = (bus.lhs[W-1] == bus.rhs[W-1]) && (sum_s[W-1] != bus.lhs[W-1]);
         end
         OP_SUB: begin
            alu_result_s = diff_s[W-1:0];
            alu_carry_s  = diff_s[W];
            alu_ovf_s    = (bus.lhs[W-1] != bus.rhs[W-1]) && (diff_s[W-1] != bus.lhs[W-1]);
         end
         OP_AND: alu_result_s = bus.lhs & bus.rhs;
         OP_OR:  alu_result_s = bus.lhs | bus.rhs;
         OP_XOR: alu_result_s = bus.lhs ^ bus.rhs;
         OP_SHL: alu_result_s = bus.lhs << shamt_s;
         OP_SHR: alu_result_s = bus.lhs >> shamt_s;
         OP_SRA: alu_result_s = $signed(bus.lhs) >>> shamt_s;
`ifdef ITER_ALU_MUL_EN
         OP_MUL, OP_MULHU: alu_result_s = {W{1'b0}};
`endif
         default: alu_illegal_s = 1'b1;
      endcase
   end

   // Assemble flag vectors for the single-cycle and multiplier results.
   always_comb begin
      alu_flags_s               = {FLAGS_W{1'b0}};
      alu_flags_s[FLAG_ILLEGAL] = alu_illegal_s;
      alu_flags_s[FLAG_OVF]     = alu_ovf_s;
      alu_flags_s[FLAG_CARRY]   = alu_carry_s;
      alu_flags_s[FLAG_NEG]     = alu_result_s[W-1];
      alu_flags_s[FLAG_ZERO]    = (alu_result_s == {W{1'b0}});
      mul_flags_s               = {FLAGS_W{1'b0}};
      mul_flags_s[FLAG_NEG]     = mul_result_s[W-1];
      mul_flags_s[FLAG_ZERO]    = (mul_result_s == {W{1'b0}});
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; an accept in DONE chains straight into the next op.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = is_mul_s ? ST_BUSY : ST_DONE;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mul_done_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (accept_s) begin
               next_state_s = is_mul_s ? ST_BUSY : ST_DONE;
            end else if (bus.out_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_DONE;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Result/flags registers: load on completion, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_r <= {W{1'b0}};
         flags_r  <= {FLAGS_W{1'b0}};
      end else if (load_alu_s) begin
         result_r <= alu_result_s;
         flags_r  <= alu_flags_s;
      end else if (load_mul_s) begin
         result_r <= mul_result_s;
         flags_r  <= mul_flags_s;
      end else begin
         result_r <= result_r;
         flags_r  <= flags_r;
      end
   end
endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at OPERAND_WIDTH=8.
// Expected results are queued when a request is driven and popped when
// the response is observed.
module tb_iter_alu;
   typedef struct packed {
      logic [7:0] res;
      logic [4:0] flg;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   int   lat;
   logic seen_valid;

   iter_alu_if #(.OPERAND_WIDTH(8)) bus ();

   iter_alu #(.OPERAND_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [4:0] ef);
      exp_t e;
      bus.in_valid  = 1'b1;
      bus.operation = op;
      bus.lhs       = a;
      bus.rhs       = b;
      e.res = er;
      e.flg = ef;
      sb.push_back(e);
   endtask

   task automatic scramble();
      bus.in_valid  = 1'b0;
      bus.operation = 5'($urandom_range(0, 31));
      bus.lhs       = 8'($urandom);
      bus.rhs       = 8'($urandom);
   endtask

   // Called just after the acceptance edge; returns at a negedge.
   task automatic wait_valid(output int n);
      n = 1;
      @(negedge clk);
      while (!bus.out_valid && n < 40) begin
         chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("valid_timeout", {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      chk({tag, "_sb"}, {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_result"}, {24'd0, bus.result}, {24'd0, e.res});
         chk({tag, "_flags"}, {27'd0, bus.flags}, {27'd0, e.flg});
      end else begin
         e = '0;
      end
   endtask

   task automatic take();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [4:0] ef,
                        input int elat);
      int n;
      drive(op, a, b, er, ef);
      @(posedge clk);
      #1 scramble();
      wait_valid(n);
      chk({tag, "_latency"}, 32'(n), 32'(elat));
      check_out(tag);
      take();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.operation = 5'd0;
      bus.lhs       = 8'd0;
      bus.rhs       = 8'd0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_result",    {24'd0, bus.result},    32'd0);
      chk("rst_flags",     {27'd0, bus.flags},     32'd0);
      @(posedge clk);
      #1;

      // flags = {illegal, overflow, carry, negative, zero}
      do_op("add_wrap", 5'd0, 8'hFF, 8'h01, 8'h00, 5'b00101, 1);
      do_op("sub_ovf",  5'd1, 8'h80, 8'h01, 8'h7F, 5'b01100, 1);
      do_op("and",      5'd2, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1);
      do_op("or",       5'd3, 8'h0F, 8'h80, 8'h8F, 5'b00010, 1);
      do_op("xor",      5'd4, 8'hAA, 8'hAA, 8'h00, 5'b00001, 1);
      do_op("shl_mask", 5'd5, 8'h81, 8'h09, 8'h02, 5'b00000, 1);
      do_op("shr",      5'd6, 8'h80, 8'h03, 8'h10, 5'b00000, 1);
      do_op("sra",      5'd7, 8'h80, 8'h03, 8'hF0, 5'b00010, 1);
      do_op("add_ovf",  5'd0, 8'h7F, 8'h01, 8'h80, 5'b01010, 1);
      do_op("sub_brw",  5'd1, 8'h05, 8'h07, 8'hFE, 5'b00010, 1);
      do_op("illegal12",5'd12, 8'h12, 8'h34, 8'h00, 5'b10001, 1);

`ifdef ITER_ALU_MUL_EN
      do_op("mul",   5'd8, 8'h0F, 8'h11, 8'hFF, 5'b00010, 9);
      do_op("mulhu", 5'd9, 8'hFF, 8'hFF, 8'hFE, 5'b00010, 9);

      // Reset at the fourth multiplier step aborts the operation.
      drive(5'd8, 8'h03, 8'h03, 8'h09, 5'b00000);
      @(posedge clk);
      #1 scramble();
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      void'(sb.pop_back());
`else
      do_op("mul_off", 5'd8, 8'h0F, 8'h11, 8'h00, 5'b10001, 1);

      // Reset while a result waits in DONE discards it.
      drive(5'd0, 8'h01, 8'h01, 8'h02, 5'b00000);
      @(posedge clk);
      #1 scramble();
      wait_valid(lat);
      void'(sb.pop_back());
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
`endif
      seen_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         seen_valid = seen_valid | bus.out_valid;
      end
      chk("abort_no_valid", {31'd0, seen_valid}, 32'd0);
      chk("abort_result",   {24'd0, bus.result}, 32'd0);
      @(posedge clk);
      #1;
      do_op("after_rst", 5'd0, 8'h02, 8'h03, 8'h05, 5'b00000, 1);

      // Back-to-back with the consumer stalling for three cycles.
      drive(5'd0, 8'h10, 8'h20, 8'h30, 5'b00000);
      @(posedge clk);
      #1 drive(5'd0, 8'hFF, 8'hFF, 8'hFE, 5'b00110);
      wait_valid(lat);
      chk("b2b_latency", 32'(lat), 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("stall_result",   {24'd0, bus.result},   {24'd0, sb[0].res});
         chk("stall_flags",    {27'd0, bus.flags},    {27'd0, sb[0].flg});
         @(posedge clk);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1 chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check_out("b2b_first");
      @(posedge clk);
      #1 scramble();
      bus.out_ready = 1'b0;
      wait_valid(lat);
      chk("b2b_second_latency", 32'(lat), 32'd1);
      check_out("b2b_second");
      take();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
